// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus launch controller feeding a UART TX FSM.
// Ports: clk/rst (sync, active-high); wr_data/wr_en/flush host side;
//        full/empty/fifo_count/overflow status; tx_busy in from TX FSM;
//        tx_data/tx_data_valid out to TX FSM (one-cycle launch strobe).
module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_data_valid
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_overflow;
    logic                  w_wr;
    logic                  w_drop;
    logic                  w_pop;

    assign full       = (r_count == CNT_FULL);
    assign empty      = (r_count == '0);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign tx_data    = r_tx_data;

    // full is taken from the registered count, so a same-edge pop
    // cannot make room for a write. flush swallows any write.
    assign w_wr   = wr_en & ~full & ~flush & ~rst;
    assign w_drop = wr_en & full & ~flush;
    // Only launch from IDLE with the TX FSM idle; flush blocks the pop.
    assign w_pop  = (r_state == S_IDLE) & ~empty & ~tx_busy & ~flush;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                if (w_wr && !w_pop) begin
                    r_count <= r_count + CNT_ONE;
                end else if (w_pop && !w_wr) begin
                    r_count <= r_count - CNT_ONE;
                end
            end
            // Held between pops so the serializer sees a stable word.
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        tx_data_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_data_valid = 1'b1;
                w_state_nxt   = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
